// File: rtl/event_encoder_pkg.sv
// Shared types and defaults for the event encoder slice.
package event_enc_pkg;

  localparam int unsigned N_DEFAULT = 8;

  typedef logic [2:0] evt_idx_t;
  typedef logic [7:0] evt_mask_t;

endpackage

// File: rtl/event_encoder_prio_sel.sv
// Find-first-set over an N-bit mask, searching upward from a start offset
// and wrapping modulo N (N is a power of two, so index addition wraps naturally).
module prio_sel #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] offset_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [W-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = offset_i + W'(i);
      if (!found_o && mask_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Sequential N-to-log2(N) event encoder with pending capture and valid/ready output.
// Define EVENT_ENCODER_ROUND_ROBIN_EN for round-robin selection instead of lowest-index priority.
module event_encoder
  import event_enc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         pending,
  output logic                 ovf
);

  localparam int unsigned W = $clog2(N);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic         out_valid_q, out_valid_d;
  logic         ovf_q, ovf_d;

  logic [W-1:0] sel_idx;
  logic         sel_found;
  logic [W-1:0] sel_offset;
  logic         load;
  logic [N-1:0] clr_mask;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr_q, rr_ptr_d;

  assign sel_offset = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load) rr_ptr_d = sel_idx + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  assign sel_offset = '0;
`endif

  prio_sel #(.N(N), .W(W)) u_sel (
    .mask_i   (pending_q),
    .offset_i (sel_offset),
    .idx_o    (sel_idx),
    .found_o  (sel_found)
  );

  // sel_found is equivalent to |pending_q
  assign load     = sel_found && (!out_valid_q || out_ready);
  assign clr_mask = load ? (N'(1) << sel_idx) : '0;

  always_comb begin
    pending_d   = (pending_q & ~clr_mask) | req;
    ovf_d       = |(req & pending_q & ~clr_mask);
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_idx_d   = sel_idx;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pending   = pending_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of pending events and the output slot.
module tb_event_encoder;
  import event_enc_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  evt_mask_t  req;
  evt_idx_t   out_idx;
  logic       out_valid;
  logic       out_ready;
  evt_mask_t  pending;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  // model state
  bit m_pend [N];
  bit m_valid;
  int m_idx;
  bit m_ovf;
  int m_rr;

  always #5 clk = ~clk;

  event_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .ovf       (ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int model_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic model_edge(input int r, input bit rdy, input bit rstn);
    bit nxt [N];
    int clr = -1;
    bit any = 0;
    bit lost = 0;
    if (!rstn) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_valid = 0; m_idx = 0; m_ovf = 0; m_rr = 0;
      return;
    end
    for (int i = 0; i < N; i++) any |= m_pend[i];
    if (any && (!m_valid || rdy)) begin
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
      int start = m_rr;
`else
      int start = 0;
`endif
      for (int k = 0; k < N; k++) begin
        int j = (start + k) % N;
        if (clr < 0 && m_pend[j]) clr = j;
      end
      m_idx   = clr;
      m_valid = 1;
      m_rr    = (clr + 1) % N;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    for (int i = 0; i < N; i++) begin
      bit keep = m_pend[i] && (i != clr);
      bit hit  = ((r >> i) & 1) != 0;
      if (hit && keep) lost = 1;
      nxt[i] = keep || hit;
    end
    for (int i = 0; i < N; i++) m_pend[i] = nxt[i];
    m_ovf = lost;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at following negedge.
  task automatic step(input int r, input bit rdy, input bit rstn);
    req       = evt_mask_t'(r);
    out_ready = rdy;
    rst_n     = rstn;
    @(posedge clk);
    model_edge(r, rdy, rstn);
    @(negedge clk);
    chk("pending", int'(pending), model_mask());
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_idx", int'(out_idx), m_idx);
    chk("ovf", int'(ovf), int'(m_ovf));
  endtask

  initial begin
    evt_mask_t dec;
    req = '0; out_ready = 1'b0; rst_n = 1'b0;
    m_valid = 0; m_idx = 0; m_ovf = 0; m_rr = 0;
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    @(negedge clk);

    // reset with all requests high
    for (int i = 0; i < 3; i++) step(8'hFF, 1'b1, 1'b0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_ovf", int'(ovf), 0);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_pending", int'(pending), 0);

    // single event
    step(8'h20, 1'b1, 1'b1);
    chk("single_pend", int'(pending), 8'h20);
    chk("single_not_bypassed", int'(out_valid), 0);
    step(0, 1'b1, 1'b1);
    chk("single_valid", int'(out_valid), 1);
    chk("single_idx", int'(out_idx), 5);
    dec = evt_mask_t'(1) << out_idx;
    chk("single_decode", int'(dec), 8'h20);
    step(0, 1'b1, 1'b1);
    chk("single_drain", int'(out_valid), 0);
    chk("single_idx_hold", int'(out_idx), 5);

    // multi-hot, fixed order with ready held
    step(8'h91, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1); chk("multi_0", int'(out_idx), 0);
    step(0, 1'b1, 1'b1); chk("multi_4", int'(out_idx), 4);
    step(0, 1'b1, 1'b1); chk("multi_7", int'(out_idx), 7);
    step(0, 1'b1, 1'b1); chk("multi_done", int'(out_valid), 0);

    // backpressure
    step(8'h91, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b0, 1'b1);
      chk("bp_idx", int'(out_idx), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_pend", int'(pending), 8'h90);
    end
    step(0, 1'b1, 1'b1); chk("bp_4", int'(out_idx), 4);
    step(0, 1'b1, 1'b1); chk("bp_7", int'(out_idx), 7);
    step(0, 1'b1, 1'b1); chk("bp_done", int'(out_valid), 0);

    // overflow while stalled
    step(8'h0A, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("ov_setup_idx", int'(out_idx), 1);
    chk("ov_setup_pend", int'(pending), 8'h08);
    step(8'h08, 1'b0, 1'b1);
    chk("ov_pulse", int'(ovf), 1);
    chk("ov_pend_same", int'(pending), 8'h08);
    step(0, 1'b0, 1'b1);
    chk("ov_one_cycle", int'(ovf), 0);
    // re-request bit 3 on the edge it loads
    step(8'h08, 1'b1, 1'b1);
    chk("simul_idx", int'(out_idx), 3);
    chk("simul_no_ovf", int'(ovf), 0);
    chk("simul_pend", int'(pending), 8'h08);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);

    // reset mid-stall
    step(8'h0F, 1'b0, 1'b1);
    step(8'h03, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0);
    chk("midrst_pend", int'(pending), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_ovf", int'(ovf), 0);
    step(0, 1'b1, 1'b1);

    // repeated 8'h03
    step(8'h03, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(8'h03, 1'b1, 1'b1);
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
      chk("rr_alt", int'(out_idx), i % 2);
`else
      chk("fixed_rep", int'(out_idx), 0);
`endif
    end
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r = int'($urandom_range(0, 255)) & int'($urandom_range(0, 255));
      bit rdy = ($urandom_range(0, 3) != 0);
      bit rs  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) r = 0;
      step(r, rdy, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
